// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: 32-entry register file with EX/WB forwarding, feeding
// the ID/EX pipeline register that drives the ALU operands X, Y and Aluc.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 2
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic [AW-1:0] Rs1,
    input  logic [AW-1:0] Rs2,
    input  logic [DW-1:0] Imm,
    input  logic          ImmSel,
    input  logic [CW-1:0] AlucIn,
    input  logic [AW-1:0] RdIn,
    input  logic          WeIn,
    input  logic          Stall,
    input  logic          Flush,
    input  logic [DW-1:0] ExR,
    input  logic          WbWe,
    input  logic [AW-1:0] WbRd,
    input  logic [DW-1:0] WbD,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic [CW-1:0] Aluc,
    output logic [AW-1:0] RdEx,
    output logic          WeEx,
    output logic          Valid
);
    localparam int NREG = 2**AW;

    logic [DW-1:0] r_regs [NREG];
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic [CW-1:0] r_aluc;
    logic [AW-1:0] r_rd;
    logic          r_we;
    logic          r_valid;

    logic          w_ex_fwd_ok;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;
    logic [DW-1:0] w_op_y;

    // Only a real instruction in EX that writes Rd may forward; bubbles never do.
    assign w_ex_fwd_ok = r_we && r_valid;

    always_comb begin
        w_rd1 = r_regs[Rs1];
        if (Rs1 == '0)
            w_rd1 = '0;
        else if (w_ex_fwd_ok && (r_rd == Rs1))
            w_rd1 = ExR;
        else if (WbWe && (WbRd == Rs1))
            w_rd1 = WbD;
    end

    always_comb begin
        w_rd2 = r_regs[Rs2];
        if (Rs2 == '0)
            w_rd2 = '0;
        else if (w_ex_fwd_ok && (r_rd == Rs2))
            w_rd2 = ExR;
        else if (WbWe && (WbRd == Rs2))
            w_rd2 = WbD;
    end

    assign w_op_y = ImmSel ? Imm : w_rd2;

    // Write-back is independent of Stall/Flush; entry 0 is never written.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (WbWe && (WbRd != '0)) begin
            r_regs[WbRd] <= WbD;
        end
    end

    // Valid qualifies X/Y/Aluc/RdEx/WeEx each cycle; there is no ready path,
    // back-pressure arrives only as Stall, and Flush (which beats Stall) inserts a bubble.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_aluc  <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_valid <= 1'b0;
        end else if (Flush) begin
            r_x     <= '0;
            r_y     <= '0;
            r_aluc  <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_valid <= 1'b0;
        end else if (!Stall) begin
            r_x     <= w_rd1;
            r_y     <= w_op_y;
            r_aluc  <= AlucIn;
            r_rd    <= RdIn;
            r_we    <= WeIn;
            r_valid <= 1'b1;
        end
    end

    assign X     = r_x;
    assign Y     = r_y;
    assign Aluc  = r_aluc;
    assign RdEx  = r_rd;
    assign WeEx  = r_we;
    assign Valid = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic,
// checked by a queue-based scoreboard against a register-file/pipeline model.
module tb_id_ex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam int EW = 2 * DW + CW + AW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic [AW-1:0] rs1, rs2, rd_in, wb_rd;
  logic [DW-1:0] imm, ex_r, wb_d;
  logic          imm_sel, we_in, stall, flush, wb_we;
  logic [CW-1:0] aluc_in;
  logic [DW-1:0] x, y;
  logic [CW-1:0] aluc;
  logic [AW-1:0] rd_ex;
  logic          we_ex, valid;

  id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .Clk(clk), .Clrn(clrn), .Rs1(rs1), .Rs2(rs2), .Imm(imm), .ImmSel(imm_sel),
    .AlucIn(aluc_in), .RdIn(rd_in), .WeIn(we_in), .Stall(stall), .Flush(flush),
    .ExR(ex_r), .WbWe(wb_we), .WbRd(wb_rd), .WbD(wb_d),
    .X(x), .Y(y), .Aluc(aluc), .RdEx(rd_ex), .WeEx(we_ex), .Valid(valid)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Architectural register file plus the instruction currently sitting in EX.
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] m_x, m_y;
  logic [CW-1:0] m_aluc;
  logic [AW-1:0] m_rd;
  logic          m_we, m_valid;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_x = '0; m_y = '0; m_aluc = '0; m_rd = '0; m_we = 1'b0; m_valid = 1'b0;
  endtask

  // Value an instruction in ID sees for source s: newest producer wins.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] s);
    if (s == '0) return '0;
    if (m_valid && m_we && m_rd == s) return ex_r;
    if (wb_we && wb_rd == s) return wb_d;
    return m_rf[s];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rs1 = '0; rs2 = '0; imm = '0; imm_sel = 1'b0; aluc_in = '0; rd_in = '0;
    we_in = 1'b0; stall = 1'b0; flush = 1'b0; ex_r = '0;
    wb_we = 1'b0; wb_rd = '0; wb_d = '0;
  endtask

  task automatic drive_cycle();
    logic [DW-1:0] nx, ny;
    logic [CW-1:0] na;
    logic [AW-1:0] nr;
    logic          nw, nv;
    if (flush) begin
      nx = '0; ny = '0; na = '0; nr = '0; nw = 1'b0; nv = 1'b0;
    end else if (stall) begin
      nx = m_x; ny = m_y; na = m_aluc; nr = m_rd; nw = m_we; nv = m_valid;
    end else begin
      nx = m_read(rs1);
      ny = imm_sel ? imm : m_read(rs2);
      na = aluc_in; nr = rd_in; nw = we_in; nv = 1'b1;
    end
    exp_q.push_back({nx, ny, na, nr, nw, nv});
    @(posedge clk);
    if (wb_we && wb_rd != '0) m_rf[wb_rd] = wb_d;
    m_x = nx; m_y = ny; m_aluc = na; m_rd = nr; m_we = nw; m_valid = nv;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called just after a falling clock edge so the reset lands between edges.
  task automatic do_reset();
    #2 clrn = 1'b0;
    #1;
    chk("rst_x", x, '0);
    chk("rst_y", y, '0);
    chk("rst_aluc", DW'(aluc), '0);
    chk("rst_rdex", DW'(rd_ex), '0);
    chk("rst_weex", DW'(we_ex), '0);
    chk("rst_valid", DW'(valid), '0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", DW'(valid), '0);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({x, y, aluc, rd_ex, we_ex, valid} !== e) begin
          failures++;
          $display("FAIL idex: got x=%h y=%h aluc=%h rd=%h we=%b v=%b expected x=%h y=%h aluc=%h rd=%h we=%b v=%b",
                   x, y, aluc, rd_ex, we_ex, valid,
                   e[EW-1 -: DW], e[EW-DW-1 -: DW], e[AW+CW+1 -: CW], e[AW+1 -: AW], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    clrn = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // zero register after reset
    set_idle(); drive_cycle();
    // write then read
    set_idle(); wb_we = 1'b1; wb_rd = 5'd3; wb_d = 32'h666; rs1 = 5'd1; drive_cycle();
    set_idle(); rs1 = 5'd3; drive_cycle();
    // same-cycle WB bypass, then write to r0 ignored
    set_idle(); wb_we = 1'b1; wb_rd = 5'd5; wb_d = 32'hC; rs1 = 5'd5; drive_cycle();
    set_idle(); wb_we = 1'b1; wb_rd = 5'd0; wb_d = 32'hFFFF_FFFF; rs1 = 5'd0; drive_cycle();
    // EX forwarding beats WB
    set_idle(); rd_in = 5'd7; we_in = 1'b1; drive_cycle();
    set_idle(); ex_r = 32'hA; wb_we = 1'b1; wb_rd = 5'd7; wb_d = 32'hB; rs2 = 5'd7; drive_cycle();
    // immediate path
    set_idle(); wb_we = 1'b1; wb_rd = 5'd4; wb_d = 32'hC; drive_cycle();
    set_idle(); rs1 = 5'd4; imm_sel = 1'b1; imm = 32'b1010; aluc_in = 2'b10; drive_cycle();

    // reset mid-run with X nonzero; register file must be cleared too
    do_reset();
    set_idle(); rs1 = 5'd3; rs2 = 5'd5; drive_cycle();

    // stall for three cycles, then stall+flush, then no forward from the bubble
    set_idle(); wb_we = 1'b1; wb_rd = 5'd9; wb_d = 32'h99; drive_cycle();
    set_idle(); rs1 = 5'd9; rd_in = 5'd9; we_in = 1'b1; aluc_in = 2'b01; drive_cycle();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      stall = 1'b1;
      rs1 = AW'($urandom_range(0, 31)); rs2 = AW'($urandom_range(0, 31));
      imm = $urandom; imm_sel = 1'($urandom_range(0, 1)); aluc_in = CW'($urandom_range(0, 3));
      rd_in = AW'($urandom_range(0, 31)); we_in = 1'($urandom_range(0, 1)); ex_r = $urandom;
      drive_cycle();
    end
    set_idle(); stall = 1'b1; flush = 1'b1; ex_r = 32'h1234; drive_cycle();
    set_idle(); rs1 = 5'd9; ex_r = 32'hDEAD; drive_cycle();

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      imm = $urandom; imm_sel = ($urandom_range(0, 3) == 0);
      aluc_in = CW'($urandom_range(0, 3));
      rd_in = AW'($urandom_range(0, 7)); we_in = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 7) == 0);
      ex_r = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_rd = AW'($urandom_range(0, 7)); wb_d = $urandom;
      drive_cycle();
    end

    set_idle();
    @(negedge clk);
    chk("queue_drained", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
Decode-to-execute operand stage that sits directly upstream of the ALU. It holds the 32x32 register file, selects operands with forwarding from the ALU result (EX) and the write-back port (WB), and registers X, Y and Aluc into the ID/EX pipeline register that drives the ALU inputs. It supports stall (hold) and flush (bubble).

Parameters:
DW, 32, datapath width (X, Y, register contents)
AW, 5, register address width (2**AW registers)
CW, 2, ALU control width (Aluc)

Ports:
Clk  in  1  clock, rising edge
Clrn  in  1  reset; asynchronous, active-low
Rs1  in  AW  source register 1 address (drives X)
Rs2  in  AW  source register 2 address (drives Y when ImmSel=0)
Imm  in  DW  immediate, already sign/zero extended upstream
ImmSel  in  1  1: Y takes Imm; 0: Y takes Rs2 operand
AlucIn  in  CW  ALU op for the decoded instruction
RdIn  in  AW  destination register of the decoded instruction
WeIn  in  1  decoded instruction writes Rd
Stall  in  1  hold the ID/EX register
Flush  in  1  load a bubble into the ID/EX register
ExR  in  DW  ALU result R for the instruction currently in EX
WbWe  in  1  write-back enable
WbRd  in  AW  write-back destination
WbD  in  DW  write-back data
X  out  DW  registered ALU operand X
Y  out  DW  registered ALU operand Y
Aluc  out  CW  registered ALU control
RdEx  out  AW  registered destination of the instruction in EX
WeEx  out  1  registered write enable of the instruction in EX
Valid  out  1  1 = EX holds a real instruction; 0 = bubble

Behaviour:
- Reset (Clrn=0, asynchronous, takes effect without a clock edge): all 32 registers, X, Y, Aluc, RdEx, WeEx and Valid are cleared to 0. Reset mid-operation discards the pipeline contents and all register-file state.
- Register file write: on the rising Clk edge, when WbWe=1 and WbRd!=0, reg[WbRd] <= WbD. Writes happen regardless of Stall or Flush. Register 0 always reads as 0, and writes to it are ignored.
- Operand read (combinational, per source s = Rs1 or Rs2), priority from highest to lowest:
  1. s==0 -> 0.
  2. WeEx && Valid && RdEx==s -> ExR (EX forwarding).
  3. WbWe && WbRd==s -> WbD (WB bypass, same-cycle write-through).
  4. Otherwise -> reg[s].
- When both EX and WB match the same source, EX wins because it is the younger instruction.
- Operand selection: opX = read(Rs1); opY = ImmSel ? Imm : read(Rs2).
- ID/EX register update on the rising edge, in priority order:
  - Flush=1 -> X=0, Y=0, Aluc=0, RdEx=0, WeEx=0, Valid=0. Flush beats Stall.
  - else Stall=1 -> all outputs hold their current values.
  - else -> X<=opX, Y<=opY, Aluc<=AlucIn, RdEx<=RdIn, WeEx<=WeIn, Valid<=1.
- Latency: operands presented in cycle n appear on X/Y/Aluc after edge n+1, which is one cycle.
- Forwarding during stall: while EX is held, ExR stays valid and forwarding stays active. The upstream unit re-presents the same Rs, so the resolved operand is stable.
- Bubbles never forward, because forwarding is gated by Valid and WeEx.
- No load-use detection in this block. Stall is generated externally.
- Width: all data paths are DW bits with no arithmetic. Address compares use the full AW bits.

Test Plan:
- Reset/zero register: assert Clrn=0 mid-run with X previously nonzero. X, Y, Aluc, RdEx, WeEx and Valid must go to 0 immediately. After release, Rs1=0 and Rs2=0 load X=0, Y=0.
- Write then read: WbWe=1, WbRd=3, WbD=32'h666 in cycle 0. In cycle 1, Rs1=3, ImmSel=0, Rs2=0 -> after the edge X=32'h666, Y=0, Valid=1.
- Same-cycle WB bypass: WbWe=1, WbRd=5, WbD=32'hC while Rs1=5 in the same cycle -> X=32'hC after the edge. Write to WbRd=0 with WbD=32'hFFFF_FFFF -> Rs1=0 reads 0.
- EX priority: EX holds RdEx=7 with WeEx=1, and ExR=32'hA. At the same time WbWe=1, WbRd=7, WbD=32'hB, and Rs2=7, ImmSel=0 -> Y=32'hA.
- Immediate path: ImmSel=1, Imm=32'b1010, Rs1 holding 32'b1100, AlucIn=2'b10 -> X=32'hC, Y=32'hA, Aluc=2'b10. This is the ALU's expected operand set.
- Stall/flush:
  - Stall=1 for 3 cycles with changing inputs -> outputs unchanged.
  - Stall=1 and Flush=1 together -> bubble with Valid=0, WeEx=0.
  - Next instruction reading RdEx does not forward ExR, and sees the register-file value instead.
